// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: shares one memory bus between an instruction-fetch port and a
// load/store port. Each port latches its request into a pending register on a
// start pulse. Whenever the arbiter is idle it grants one pending request, issues
// it on the bus, and routes the bus completion back to the requesting port.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   insn_start, insn_addr         fetch request pulse and word address
//   insn_ready, insn_data_rd      fetch completion pulse and read data
//   data_start, data_write,       load/store request pulse, direction,
//   data_addr, data_data_wr,      word address, store data and byte enables
//   data_data_be
//   data_ready, data_data_rd      load/store completion pulse and load data
//   bus_start, bus_write,         shared-bus transaction start pulse and payload
//   bus_addr, bus_data_wr,        (payload stable for the whole transaction,
//   bus_data_be                   zero while idle)
//   bus_ready, bus_data_rd        shared-bus completion pulse and read data
//
// Configuration
//   ARB_ROUND_ROBIN_EN  defined: on contention, grant the port not granted last
//                       (the first contention after reset goes to insn).
//                       undefined: fixed priority, data wins on contention.

module core_mem_arbiter (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        insn_start,
  input  logic [29:0] insn_addr,
  output logic        insn_ready,
  output logic [31:0] insn_data_rd,

  input  logic        data_start,
  input  logic        data_write,
  input  logic [29:0] data_addr,
  input  logic [31:0] data_data_wr,
  input  logic [3:0]  data_data_be,
  output logic        data_ready,
  output logic [31:0] data_data_rd,

  output logic        bus_start,
  output logic        bus_write,
  output logic [29:0] bus_addr,
  output logic [31:0] bus_data_wr,
  output logic [3:0]  bus_data_be,
  input  logic        bus_ready,
  input  logic [31:0] bus_data_rd
);

  typedef enum logic [1:0] {
    StIdle,
    StBusyI,
    StBusyD
  } state_e;

  state_e state_q, state_d;

  // Pending registers. A port's pending flag stays set while its request is on
  // the bus, so a second start pulse is ignored until the completion cycle.
  logic        i_pend_q, i_pend_d;
  logic [29:0] i_addr_q, i_addr_d;

  logic        d_pend_q, d_pend_d;
  logic        d_write_q, d_write_d;
  logic [29:0] d_addr_q, d_addr_d;
  logic [31:0] d_wdata_q, d_wdata_d;
  logic [3:0]  d_be_q, d_be_d;

  logic        bus_start_q, bus_start_d;

  logic        i_take, d_take;
  logic        i_req, d_req;
  logic        grant_i, grant_d;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 when the most recent grant went to the data port.
  logic        last_data_q, last_data_d;
`endif

  // A start is accepted only when the port has nothing pending or in flight.
  assign i_take = insn_start & ~i_pend_q;
  assign d_take = data_start & ~d_pend_q;

  // Requests visible to the idle-state arbiter include this cycle's start pulses,
  // giving a one-cycle start-to-bus_start latency.
  assign i_req = i_pend_q | insn_start;
  assign d_req = d_pend_q | data_start;

  // Grant decision, only meaningful in the idle state.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == StIdle) begin
      if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
        grant_d = ~last_data_q;
        grant_i = last_data_q;
`else
        grant_d = 1'b1;
`endif
      end else begin
        grant_i = i_req;
        grant_d = d_req;
      end
    end
  end

  // Next-state logic for the FSM and the pending registers.
  always_comb begin
    state_d     = state_q;
    bus_start_d = 1'b0;

    i_pend_d    = i_pend_q;
    i_addr_d    = i_addr_q;
    d_pend_d    = d_pend_q;
    d_write_d   = d_write_q;
    d_addr_d    = d_addr_q;
    d_wdata_d   = d_wdata_q;
    d_be_d      = d_be_q;

    if (i_take) begin
      i_pend_d = 1'b1;
      i_addr_d = insn_addr;
    end
    if (d_take) begin
      d_pend_d  = 1'b1;
      d_write_d = data_write;
      d_addr_d  = data_addr;
      d_wdata_d = data_data_wr;
      d_be_d    = data_data_be;
    end

    unique case (state_q)
      StIdle: begin
        // bus_ready while idle is a stray pulse and is dropped here.
        if (grant_i) begin
          state_d     = StBusyI;
          bus_start_d = 1'b1;
        end else if (grant_d) begin
          state_d     = StBusyD;
          bus_start_d = 1'b1;
        end
      end
      StBusyI: begin
        if (bus_ready) begin
          state_d  = StIdle;
          i_pend_d = 1'b0;
        end
      end
      StBusyD: begin
        if (bus_ready) begin
          state_d  = StIdle;
          d_pend_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    last_data_d = last_data_q;
    if (grant_d) begin
      last_data_d = 1'b1;
    end else if (grant_i) begin
      last_data_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_data_q <= 1'b1;
    end else begin
      last_data_q <= last_data_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bus_start_q <= 1'b0;
      i_pend_q    <= 1'b0;
      i_addr_q    <= '0;
      d_pend_q    <= 1'b0;
      d_write_q   <= 1'b0;
      d_addr_q    <= '0;
      d_wdata_q   <= '0;
      d_be_q      <= '0;
    end else begin
      state_q     <= state_d;
      bus_start_q <= bus_start_d;
      i_pend_q    <= i_pend_d;
      i_addr_q    <= i_addr_d;
      d_pend_q    <= d_pend_d;
      d_write_q   <= d_write_d;
      d_addr_q    <= d_addr_d;
      d_wdata_q   <= d_wdata_d;
      d_be_q      <= d_be_d;
    end
  end

  assign bus_start = bus_start_q;

  // Bus payload comes straight from the granted pending register, so it is
  // stable for the whole transaction. Fetches are always full-word reads.
  always_comb begin
    bus_write   = 1'b0;
    bus_addr    = '0;
    bus_data_wr = '0;
    bus_data_be = '0;
    unique case (state_q)
      StBusyI: begin
        bus_addr    = i_addr_q;
        bus_data_be = 4'b1111;
      end
      StBusyD: begin
        bus_write   = d_write_q;
        bus_addr    = d_addr_q;
        bus_data_wr = d_wdata_q;
        bus_data_be = d_be_q;
      end
      default: ;
    endcase
  end

  // Completion is combinational from bus_ready; read data is gated to zero
  // outside the ready pulse.
  assign insn_ready   = (state_q == StBusyI) & bus_ready;
  assign data_ready   = (state_q == StBusyD) & bus_ready;
  assign insn_data_rd = insn_ready ? bus_data_rd : 32'h0;
  assign data_data_rd = data_ready ? bus_data_rd : 32'h0;

endmodule

// File: tb/tb_core_mem_arbiter.sv
module tb_core_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        insn_start = 1'b0;
  logic [29:0] insn_addr = '0;
  logic        insn_ready;
  logic [31:0] insn_data_rd;
  logic        data_start = 1'b0;
  logic        data_write = 1'b0;
  logic [29:0] data_addr = '0;
  logic [31:0] data_data_wr = '0;
  logic [3:0]  data_data_be = '0;
  logic        data_ready;
  logic [31:0] data_data_rd;
  logic        bus_start;
  logic        bus_write;
  logic [29:0] bus_addr;
  logic [31:0] bus_data_wr;
  logic [3:0]  bus_data_be;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_data_rd = '0;

  core_mem_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .insn_start   (insn_start),
    .insn_addr    (insn_addr),
    .insn_ready   (insn_ready),
    .insn_data_rd (insn_data_rd),
    .data_start   (data_start),
    .data_write   (data_write),
    .data_addr    (data_addr),
    .data_data_wr (data_data_wr),
    .data_data_be (data_data_be),
    .data_ready   (data_ready),
    .data_data_rd (data_data_rd),
    .bus_start    (bus_start),
    .bus_write    (bus_write),
    .bus_addr     (bus_addr),
    .bus_data_wr  (bus_data_wr),
    .bus_data_be  (bus_data_be),
    .bus_ready    (bus_ready),
    .bus_data_rd  (bus_data_rd)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_wide(input string name, input logic [133:0] act, input logic [133:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: per-port request records plus the index of the port that
  // owns the bus (0 none, 1 insn, 2 data). Outputs are derived from the record
  // of the owner; compared on every falling edge.
  // ---------------------------------------------------------------------------
  bit          m_pi = 0, m_pd = 0, m_bs = 0, m_last_d = 1;
  logic [29:0] m_ai = '0, m_ad = '0;
  logic        m_wd = 0;
  logic [31:0] m_wrd = '0;
  logic [3:0]  m_bed = '0;
  int          m_owner = 0;
  int          cnt_bs = 0, cnt_ir = 0, cnt_dr = 0;

  always @(negedge clk) begin : model
    logic [133:0] exp_v, act_v;
    logic         ir, dr, ew;
    logic [29:0]  ea;
    logic [31:0]  ewr;
    logic [3:0]   ebe;
    act_v = {bus_start, bus_write, bus_addr, bus_data_wr, bus_data_be,
             insn_ready, insn_data_rd, data_ready, data_data_rd};
    if (!rst_n) begin
      m_pi = 0; m_pd = 0; m_owner = 0; m_bs = 0; m_last_d = 1;
      exp_v = '0;
    end else begin
      ea = '0; ew = 1'b0; ewr = '0; ebe = '0;
      if (m_owner == 1) begin
        ea = m_ai; ebe = 4'hf;
      end else if (m_owner == 2) begin
        ew = m_wd; ea = m_ad; ewr = m_wrd; ebe = m_bed;
      end
      ir = (m_owner == 1) && bus_ready;
      dr = (m_owner == 2) && bus_ready;
      exp_v = {m_bs, ew, ea, ewr, ebe, ir, ir ? bus_data_rd : 32'h0,
               dr, dr ? bus_data_rd : 32'h0};
    end
    chk_wide("per-cycle outputs", act_v, exp_v);
    if (bus_start === 1'b1) cnt_bs++;
    if (insn_ready === 1'b1) cnt_ir++;
    if (data_ready === 1'b1) cnt_dr++;

    if (rst_n) begin
      if (insn_start && !m_pi) begin
        m_pi = 1; m_ai = insn_addr;
      end
      if (data_start && !m_pd) begin
        m_pd = 1; m_wd = data_write; m_ad = data_addr; m_wrd = data_data_wr; m_bed = data_data_be;
      end
      m_bs = 0;
      if (m_owner != 0) begin
        if (bus_ready) begin
          if (m_owner == 1) m_pi = 0;
          else m_pd = 0;
          m_owner = 0;
        end
      end else if (m_pi || m_pd) begin
        if (m_pi && m_pd) begin
`ifdef ARB_ROUND_ROBIN_EN
          m_owner = m_last_d ? 1 : 2;
`else
          m_owner = 2;
`endif
        end else begin
          m_owner = m_pi ? 1 : 2;
        end
        m_last_d = (m_owner == 2);
        m_bs = 1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus with hand-computed expectations.
  // ---------------------------------------------------------------------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_starts();
    insn_start = 0; insn_addr = '0;
    data_start = 0; data_write = 0; data_addr = '0; data_data_wr = '0; data_data_be = '0;
  endtask

  // Leaves the caller at the falling edge of the bus_start cycle.
  task automatic wait_bs(input string name);
    bit found;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_start === 1'b1) begin
        found = 1;
        break;
      end
      next_cycle();
    end
    chk({name, " bus_start seen"}, 32'(found), 32'd1);
  endtask

  // Called from the bus_start cycle: completes the transaction one cycle later,
  // leaving the caller at the falling edge of the bus_ready cycle.
  task automatic give_ready(input logic [31:0] rd);
    next_cycle();
    bus_ready = 1; bus_data_rd = rd;
    @(negedge clk);
  endtask

  task automatic drop_ready();
    next_cycle();
    bus_ready = 0; bus_data_rd = '0;
  endtask

  task automatic contention(input string name, input logic [29:0] ia, input logic [29:0] da,
                            input bit data_first);
    next_cycle();
    insn_start = 1; insn_addr = ia;
    data_start = 1; data_write = 0; data_addr = da;
    next_cycle();
    clear_starts();
    @(negedge clk);
    chk({name, " first bus_start"}, 32'(bus_start), 32'd1);
    chk({name, " first addr"}, 32'(bus_addr), data_first ? 32'(da) : 32'(ia));
    give_ready(32'h1111_1111);
    chk({name, " first ready"}, {30'd0, insn_ready, data_ready}, data_first ? 32'd1 : 32'd2);
    drop_ready();
    wait_bs(name);
    chk({name, " second addr"}, 32'(bus_addr), data_first ? 32'(ia) : 32'(da));
    give_ready(32'h2222_2222);
    chk({name, " second ready"}, {30'd0, insn_ready, data_ready}, data_first ? 32'd2 : 32'd1);
    drop_ready();
  endtask

  int b_bs, b_ir, b_dr;

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    clear_starts();
    repeat (2) next_cycle();
    @(negedge clk);
    chk("reset bus_start", 32'(bus_start), 32'd0);
    chk("reset bus_addr", 32'(bus_addr), 32'd0);
    next_cycle();
    rst_n = 1;
    next_cycle();

    // Single fetch: start at t, bus_start at t+1, ready at t+3.
    b_ir = cnt_ir;
    insn_start = 1; insn_addr = 30'h100;
    next_cycle();
    clear_starts();
    @(negedge clk);
    chk("fetch bus_start", 32'(bus_start), 32'd1);
    chk("fetch bus_addr", 32'(bus_addr), 32'h100);
    chk("fetch bus_be", 32'(bus_data_be), 32'hf);
    chk("fetch bus_write", 32'(bus_write), 32'd0);
    next_cycle();
    next_cycle();
    bus_ready = 1; bus_data_rd = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("fetch insn_ready", 32'(insn_ready), 32'd1);
    chk("fetch insn_data_rd", insn_data_rd, 32'hDEAD_BEEF);
    drop_ready();
    chk("fetch ready count", 32'(cnt_ir - b_ir), 32'd1);

    // Store: payload held stable until bus_ready.
    b_dr = cnt_dr;
    next_cycle();
    data_start = 1; data_write = 1; data_addr = 30'h20;
    data_data_wr = 32'h1234_5678; data_data_be = 4'b0011;
    next_cycle();
    clear_starts();
    @(negedge clk);
    chk("store bus_write", 32'(bus_write), 32'd1);
    chk("store bus_addr", 32'(bus_addr), 32'h20);
    chk("store bus_data_wr", bus_data_wr, 32'h1234_5678);
    chk("store bus_be", 32'(bus_data_be), 32'h3);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("store held addr", 32'(bus_addr), 32'h20);
    chk("store held data", bus_data_wr, 32'h1234_5678);
    give_ready(32'h0);
    chk("store data_ready", 32'(data_ready), 32'd1);
    drop_ready();
    @(negedge clk);
    chk("store idle addr", 32'(bus_addr), 32'd0);
    chk("store ready count", 32'(cnt_dr - b_dr), 32'd1);

    // Contention, a single fetch, then contention again.
`ifdef ARB_ROUND_ROBIN_EN
    contention("contend1", 30'h40, 30'h80, 1'b0);
`else
    contention("contend1", 30'h40, 30'h80, 1'b1);
`endif
    next_cycle();
    insn_start = 1; insn_addr = 30'h44;
    next_cycle();
    clear_starts();
    give_ready(32'h4444_4444);
    drop_ready();
    // Last grant was insn, so both builds serve data first here.
    contention("contend2", 30'h48, 30'h88, 1'b1);

    // Data start during an insn transaction; a repeated insn start in the
    // insn bus_ready cycle is dropped.
    b_bs = cnt_bs;
    next_cycle();
    insn_start = 1; insn_addr = 30'h200;
    next_cycle();
    clear_starts();
    next_cycle();
    data_start = 1; data_write = 1; data_addr = 30'h300;
    data_data_wr = 32'hA5A5_A5A5; data_data_be = 4'hC;
    next_cycle();
    clear_starts();
    bus_ready = 1; bus_data_rd = 32'h0BAD_F00D;
    insn_start = 1; insn_addr = 30'h3FF;
    @(negedge clk);
    chk("busyI insn_data_rd", insn_data_rd, 32'h0BAD_F00D);
    drop_ready();
    clear_starts();
    @(negedge clk);
    chk("gap cycle bus_start", 32'(bus_start), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("queued data bus_start", 32'(bus_start), 32'd1);
    chk("queued data addr", 32'(bus_addr), 32'h300);
    chk("queued data wr", bus_data_wr, 32'hA5A5_A5A5);
    chk("queued data be", 32'(bus_data_be), 32'hC);
    give_ready(32'h0);
    drop_ready();
    repeat (4) next_cycle();
    chk("queued bus_start count", 32'(cnt_bs - b_bs), 32'd2);

    // Reset in the middle of a transaction.
    b_ir = cnt_ir;
    insn_start = 1; insn_addr = 30'h10;
    next_cycle();
    clear_starts();
    @(negedge clk);
    chk("pre-reset bus_start", 32'(bus_start), 32'd1);
    next_cycle();
    rst_n = 0;
    @(negedge clk);
    chk("in-reset bus_addr", 32'(bus_addr), 32'd0);
    chk("in-reset bus_be", 32'(bus_data_be), 32'd0);
    next_cycle();
    next_cycle();
    rst_n = 1;
    next_cycle();
    bus_ready = 1; bus_data_rd = 32'h7777_7777;
    @(negedge clk);
    chk("post-reset insn_ready", 32'(insn_ready), 32'd0);
    chk("post-reset insn_data_rd", insn_data_rd, 32'd0);
    drop_ready();
    data_start = 1; data_write = 0; data_addr = 30'h55;
    next_cycle();
    clear_starts();
    @(negedge clk);
    chk("post-reset load addr", 32'(bus_addr), 32'h55);
    give_ready(32'h5555_AAAA);
    chk("post-reset load data", data_data_rd, 32'h5555_AAAA);
    drop_ready();
    chk("abandoned fetch ready count", 32'(cnt_ir - b_ir), 32'd0);

    // Stray bus_ready while idle, then a duplicate fetch start.
    b_bs = cnt_bs; b_ir = cnt_ir; b_dr = cnt_dr;
    next_cycle();
    bus_ready = 1; bus_data_rd = 32'h9999_9999;
    @(negedge clk);
    chk("stray ready", {30'd0, insn_ready, data_ready}, 32'd0);
    drop_ready();
    insn_start = 1; insn_addr = 30'h60;
    next_cycle();
    insn_start = 1; insn_addr = 30'h61;
    @(negedge clk);
    chk("dup fetch addr", 32'(bus_addr), 32'h60);
    next_cycle();
    clear_starts();
    bus_ready = 1; bus_data_rd = 32'h6060_6060;
    @(negedge clk);
    drop_ready();
    repeat (4) next_cycle();
    chk("dup bus_start count", 32'(cnt_bs - b_bs), 32'd1);
    chk("dup insn_ready count", 32'(cnt_ir - b_ir), 32'd1);
    chk("dup data_ready count", 32'(cnt_dr - b_dr), 32'd0);

    repeat (2) next_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
